// File: rtl/cmp_zelg_serial_if.sv
// Request/result bundle for the serial magnitude comparator.
// The slave side is the comparator, the master side is the requester/consumer.
interface cmp_zelg_serial_if #(
  parameter int p_WIDTH = 32,
  parameter int p_CHUNK = 8
);
  localparam int lp_N  = p_WIDTH / p_CHUNK;
  localparam int lp_CW = $clog2(lp_N + 1);

  logic               i_valid;
  logic               o_ready;
  logic [p_WIDTH-1:0] iv_x;
  logic [p_WIDTH-1:0] iv_y;
  logic               i_signed;
  logic               o_valid;
  logic               i_ready;
  logic               o_zero;
  logic               o_equal;
  logic               o_less;
  logic               o_greater;
  logic [lp_CW-1:0]   ov_cycles;

  modport slave (
    input  i_valid, iv_x, iv_y, i_signed, i_ready,
    output o_ready, o_valid, o_zero, o_equal, o_less, o_greater, ov_cycles
  );

  modport master (
    output i_valid, iv_x, iv_y, i_signed, i_ready,
    input  o_ready, o_valid, o_zero, o_equal, o_less, o_greater, ov_cycles
  );
endinterface

// File: rtl/cmp_zelg_serial.sv
// Multi-cycle zero/equal/less/greater comparator. Operands are compared
// p_CHUNK bits per clock, MSB chunk first, stopping at the first chunk that
// differs. Signed mode flips the sign bit of both operands at capture so the
// unsigned chunk compare yields two's-complement order.
module cmp_zelg_serial #(
  parameter int p_WIDTH = 32,
  parameter int p_CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  cmp_zelg_serial_if.slave bus
);
  localparam int lp_N  = p_WIDTH / p_CHUNK;
  localparam int lp_CW = $clog2(lp_N + 1);
  localparam logic [p_WIDTH-1:0] lp_MSB = p_WIDTH'(1) << (p_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [p_WIDTH-1:0] x_r;
  logic [p_WIDTH-1:0] y_r;
  logic               zero_r;
  logic [lp_CW-1:0]   idx;
  logic [lp_CW-1:0]   cnt;
  logic [lp_CW-1:0]   cnt_inc;
  logic [p_CHUNK-1:0] cx;
  logic [p_CHUNK-1:0] cy;
  logic [p_WIDTH-1:0] bias;
  logic               accept;

  assign bias        = bus.i_signed ? lp_MSB : '0;
  assign bus.o_ready = (state == IDLE) && !i_reset;
  assign accept      = bus.i_valid && bus.o_ready;
  assign cx          = x_r[idx*p_CHUNK +: p_CHUNK];
  assign cy          = y_r[idx*p_CHUNK +: p_CHUNK];
  assign cnt_inc     = cnt + lp_CW'(1);

  // Operand capture at accept; zero detect uses the un-biased operands.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      x_r    <= bus.iv_x ^ bias;
      y_r    <= bus.iv_y ^ bias;
      zero_r <= (bus.iv_x == '0) && (bus.iv_y == '0);
    end
  end

  // Control FSM with registered result flags and cycle count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      bus.o_valid   <= 1'b0;
      bus.o_zero    <= 1'b0;
      bus.o_equal   <= 1'b0;
      bus.o_less    <= 1'b0;
      bus.o_greater <= 1'b0;
      bus.ov_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx   <= lp_CW'(lp_N - 1);
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt_inc;
          if (cx != cy) begin
            bus.o_greater <= (cx > cy);
            bus.o_less    <= (cx < cy);
            bus.o_equal   <= 1'b0;
            bus.o_zero    <= 1'b0;
            bus.ov_cycles <= cnt_inc;
            bus.o_valid   <= 1'b1;
            state         <= DONE;
          end else if (idx == '0) begin
            bus.o_greater <= 1'b0;
            bus.o_less    <= 1'b0;
            bus.o_equal   <= 1'b1;
            bus.o_zero    <= zero_r;
            bus.ov_cycles <= cnt_inc;
            bus.o_valid   <= 1'b1;
            state         <= DONE;
          end else begin
            idx <= idx - lp_CW'(1);
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            bus.o_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_zelg_serial.sv
// Bench for cmp_zelg_serial: a 32/8 instance and an 8/8 instance, directed
// vectors plus randomized operands checked against an arithmetic model.
module tb_cmp_zelg_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cmp_zelg_serial_if #(.p_WIDTH(32), .p_CHUNK(8)) a ();
  cmp_zelg_serial_if #(.p_WIDTH(8),  .p_CHUNK(8)) b ();

  cmp_zelg_serial #(.p_WIDTH(32), .p_CHUNK(8)) dut_a (.i_clk(clk), .i_reset(rst), .bus(a.slave));
  cmp_zelg_serial #(.p_WIDTH(8),  .p_CHUNK(8)) dut_b (.i_clk(clk), .i_reset(rst), .bus(b.slave));

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic [3:0]  f;   // {zero, equal, less, greater}
    int          k;
  } vec_t;

  vec_t tbl [8] = '{
    '{32'h12345678, 32'h12345679, 1'b0, 4'b0010, 4},
    '{32'h80000000, 32'h7FFFFFFF, 1'b0, 4'b0001, 1},
    '{32'h80000000, 32'h7FFFFFFF, 1'b1, 4'b0010, 1},
    '{32'h00000000, 32'h00000000, 1'b0, 4'b1100, 4},
    '{32'h00000000, 32'h00000000, 1'b1, 4'b1100, 4},
    '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4'b0100, 4},
    '{32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 4'b0100, 4},
    '{32'hFFFFFF00, 32'h00000001, 1'b1, 4'b0010, 1}
  };

  // Reference: order from plain integer compare, compare count from the
  // position of the most significant differing byte.
  function automatic void model32(input logic [31:0] x, input logic [31:0] y,
                                  input logic s, output logic [3:0] f, output int k);
    logic lt;
    bit   found;
    k = 4;
    found = 0;
    for (int i = 3; i >= 0; i--) begin
      if (!found && (((x >> (8*i)) & 32'hFF) != ((y >> (8*i)) & 32'hFF))) begin
        k = 4 - i;
        found = 1;
      end
    end
    lt = s ? ($signed(x) < $signed(y)) : (x < y);
    if (x == y) f = {(x == 32'd0), 1'b1, 2'b00};
    else        f = {2'b00, lt, !lt};
  endfunction

  function automatic logic [3:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic lt;
    lt = s ? ($signed(x) < $signed(y)) : (x < y);
    if (x == y) return {(x == 8'd0), 1'b1, 2'b00};
    return {2'b00, lt, !lt};
  endfunction

  task automatic txn_a(input logic [31:0] x, input logic [31:0] y, input logic s,
                       output logic [3:0] f, output int cyc, output int lat, output bit to);
    int n;
    to = 0;
    n = 0;
    while (a.o_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) to = 1;
    a.iv_x = x; a.iv_y = y; a.i_signed = s; a.i_valid = 1'b1;
    @(negedge clk);
    a.i_valid = 1'b0; a.iv_x = $urandom; a.iv_y = $urandom; a.i_signed = 1'($urandom_range(0, 1));
    lat = 0;
    while (a.o_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    if (lat >= 20) to = 1;
    f = {a.o_zero, a.o_equal, a.o_less, a.o_greater};
    cyc = int'(a.ov_cycles);
  endtask

  task automatic release_a();
    a.i_ready = 1'b1;
    @(negedge clk);
    a.i_ready = 1'b0;
  endtask

  task automatic txn_b(input logic [7:0] x, input logic [7:0] y, input logic s,
                       output logic [3:0] f, output int cyc, output int lat, output bit to);
    int n;
    to = 0;
    n = 0;
    while (b.o_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) to = 1;
    b.iv_x = x; b.iv_y = y; b.i_signed = s; b.i_valid = 1'b1;
    @(negedge clk);
    b.i_valid = 1'b0; b.iv_x = 8'($urandom); b.iv_y = 8'($urandom);
    lat = 0;
    while (b.o_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    if (lat >= 20) to = 1;
    f = {b.o_zero, b.o_equal, b.o_less, b.o_greater};
    cyc = int'(b.ov_cycles);
    b.i_ready = 1'b1;
    @(negedge clk);
    b.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a.o_valid, a.o_zero, a.o_equal, a.o_less, a.o_greater} !== 5'b0) begin
      errors++; $display("FAIL reset_flags_a got=%b exp=00000", {a.o_valid, a.o_zero, a.o_equal, a.o_less, a.o_greater});
    end
    checks++;
    if (a.ov_cycles !== 3'd0) begin errors++; $display("FAIL reset_cycles_a got=%0d exp=0", a.ov_cycles); end
    checks++;
    if (a.o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_a got=%b exp=0", a.o_ready); end
    checks++;
    if ({b.o_valid, b.o_zero, b.o_equal, b.o_less, b.o_greater, b.ov_cycles} !== 6'b0) begin
      errors++; $display("FAIL reset_b got=%b exp=000000", {b.o_valid, b.o_zero, b.o_equal, b.o_less, b.o_greater, b.ov_cycles});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (a.o_ready !== 1'b1 || b.o_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got=%b%b exp=11", a.o_ready, b.o_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [3:0] f;
    int cyc, lat;
    bit to;
    for (int i = 0; i < 8; i++) begin
      txn_a(tbl[i].x, tbl[i].y, tbl[i].s, f, cyc, lat, to);
      checks++;
      if (to) begin errors++; $display("FAIL dir%0d_timeout got=timeout exp=o_valid", i); end
      checks++;
      if (f !== tbl[i].f) begin errors++; $display("FAIL dir%0d_flags got=%b exp=%b", i, f, tbl[i].f); end
      checks++;
      if (cyc != tbl[i].k) begin errors++; $display("FAIL dir%0d_cycles got=%0d exp=%0d", i, cyc, tbl[i].k); end
      checks++;
      if (lat != tbl[i].k) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, tbl[i].k); end
      release_a();
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic        s;
    logic [3:0]  f, ef;
    int cyc, lat, ek;
    bit to;
    for (int i = 0; i < 60; i++) begin
      x = $urandom;
      y = x;
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 2) == 0) y[8*c +: 8] = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin x = '0; y = '0; end
      s = 1'($urandom_range(0, 1));
      model32(x, y, s, ef, ek);
      txn_a(x, y, s, f, cyc, lat, to);
      checks++;
      if (to || f !== ef) begin
        errors++; $display("FAIL rnd%0d_flags x=%h y=%h s=%b got=%b exp=%b to=%b", i, x, y, s, f, ef, to);
      end
      checks++;
      if (cyc != ek || lat != ek) begin
        errors++; $display("FAIL rnd%0d_cycles x=%h y=%h got=%0d/%0d exp=%0d", i, x, y, cyc, lat, ek);
      end
      release_a();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] f;
    int cyc, lat;
    bit to;
    txn_a(32'h000000A5, 32'h000000A6, 1'b0, f, cyc, lat, to);
    checks++;
    if (to || f !== 4'b0010 || cyc != 4) begin
      errors++; $display("FAIL bp_first got=%b/%0d exp=0010/4", f, cyc);
    end
    a.i_valid = 1'b1; a.iv_x = 32'h00000100; a.iv_y = 32'h00000001; a.i_signed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({a.o_valid, a.o_ready, a.o_zero, a.o_equal, a.o_less, a.o_greater} !== 6'b100010 || a.ov_cycles !== 3'd4) begin
        errors++;
        $display("FAIL bp_hold%0d got=%b%b%b%b%b%b/%0d exp=100010/4", i, a.o_valid, a.o_ready,
                 a.o_zero, a.o_equal, a.o_less, a.o_greater, a.ov_cycles);
      end
    end
    a.i_ready = 1'b1;
    @(negedge clk);
    a.i_ready = 1'b0;
    checks++;
    if (a.o_valid !== 1'b0 || a.o_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got=v%b r%b exp=v0 r1", a.o_valid, a.o_ready);
    end
    @(negedge clk);
    a.i_valid = 1'b0;
    checks++;
    if (a.o_ready !== 1'b0) begin errors++; $display("FAIL bp_accept_ready got=%b exp=0", a.o_ready); end
    lat = 0;
    while (a.o_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    checks++;
    if ({a.o_zero, a.o_equal, a.o_less, a.o_greater} !== 4'b0001 || a.ov_cycles !== 3'd3 || lat != 3) begin
      errors++;
      $display("FAIL bp_second got=%b%b%b%b/%0d lat=%0d exp=0001/3 lat=3", a.o_zero, a.o_equal,
               a.o_less, a.o_greater, a.ov_cycles, lat);
    end
    release_a();
  endtask

  task automatic test_reset_midop();
    logic [3:0] f;
    int cyc, lat;
    bit to;
    bit seen;
    a.iv_x = 32'h11223344; a.iv_y = 32'h11223344; a.i_signed = 1'b0; a.i_valid = 1'b1;
    @(negedge clk);
    a.i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a.o_valid, a.o_zero, a.o_equal, a.o_less, a.o_greater} !== 5'b0 || a.ov_cycles !== 3'd0 || a.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset got=%b%b%b%b%b/%0d r%b exp=00000/0 r0", a.o_valid, a.o_zero,
               a.o_equal, a.o_less, a.o_greater, a.ov_cycles, a.o_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (a.o_ready !== 1'b1) begin errors++; $display("FAIL midop_ready got=%b exp=1", a.o_ready); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a.o_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midop_no_valid got=1 exp=0"); end
    txn_a(32'd5, 32'd3, 1'b0, f, cyc, lat, to);
    checks++;
    if (to || f !== 4'b0001 || cyc != 4 || lat != 4) begin
      errors++; $display("FAIL midop_next got=%b/%0d lat=%0d exp=0001/4 lat=4", f, cyc, lat);
    end
    release_a();
  endtask

  task automatic test_w8();
    logic [7:0] x, y;
    logic       s;
    logic [3:0] f, ef;
    int cyc, lat;
    bit to;
    txn_b(8'hFF, 8'h01, 1'b1, f, cyc, lat, to);
    checks++;
    if (to || f !== 4'b0010 || cyc != 1 || lat != 1) begin
      errors++; $display("FAIL w8_signed got=%b/%0d lat=%0d exp=0010/1 lat=1", f, cyc, lat);
    end
    txn_b(8'hFF, 8'h01, 1'b0, f, cyc, lat, to);
    checks++;
    if (to || f !== 4'b0001 || cyc != 1 || lat != 1) begin
      errors++; $display("FAIL w8_unsigned got=%b/%0d lat=%0d exp=0001/1 lat=1", f, cyc, lat);
    end
    for (int i = 0; i < 20; i++) begin
      x = 8'($urandom);
      y = ($urandom_range(0, 3) == 0) ? x : 8'($urandom);
      s = 1'($urandom_range(0, 1));
      ef = model8(x, y, s);
      txn_b(x, y, s, f, cyc, lat, to);
      checks++;
      if (to || f !== ef || cyc != 1 || lat != 1) begin
        errors++; $display("FAIL w8_rnd%0d x=%h y=%h s=%b got=%b/%0d exp=%b/1", i, x, y, s, f, cyc, ef);
      end
    end
  endtask

  initial begin
    a.i_valid = 1'b0; a.i_ready = 1'b0; a.iv_x = '0; a.iv_y = '0; a.i_signed = 1'b0;
    b.i_valid = 1'b0; b.i_ready = 1'b0; b.iv_x = '0; b.iv_y = '0; b.i_signed = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midop();
    test_w8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
